// File: rtl/debounce_pkg.sv
// Shared state encoding and default timing for the switch debounce channels.
package debounce_pkg;

    // 10 ms of stable level at 50 MHz
    localparam int unsigned CNT_MAX_DEFAULT = 500000;

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: 2-flop synchroniser feeding a counter-based debounce FSM
// with registered level and one-cycle rise/fall pulses.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clean_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Synchroniser plus all FSM state and output registers
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Any return to the accepted level before acceptance zeroes the count
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_LO: begin
                if (r_s2) begin
                    w_state_nxt = ST_WAIT_HI;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!r_s2) begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HI;
                    w_cnt_nxt   = '0;
                    w_clean_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (!r_s2) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_LO: begin
                if (r_s2) begin
                    w_state_nxt = ST_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                    w_clean_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LO;
                w_cnt_nxt   = '0;
                w_clean_nxt = 1'b0;
            end
        endcase
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/switch_debounce_sync.sv
// Slide-switch front end: WIDTH independent synchronise-and-debounce channels
// producing clean levels and one-cycle edge pulses.
module switch_debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] SW_raw,
    output logic [WIDTH-1:0] SW_clean,
    output logic [WIDTH-1:0] SW_rise,
    output logic [WIDTH-1:0] SW_fall
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
        debounce_chan #(
            .CNT_MAX (CNT_MAX)
        ) u_chan (
            .Clk     (Clk),
            .Resetn  (Resetn),
            .i_raw   (SW_raw[i]),
            .o_clean (SW_clean[i]),
            .o_rise  (SW_rise[i]),
            .o_fall  (SW_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed bench for switch_debounce_sync with CNT_MAX=4: expected per-cycle
// outputs are queued with each stimulus step and popped as cycles elapse.
module tb_switch_debounce_sync;
    import debounce_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned CM = 4;

    logic         Clk = 1'b0;
    logic         Resetn;
    logic [W-1:0] SW_raw;
    logic [W-1:0] SW_clean;
    logic [W-1:0] SW_rise;
    logic [W-1:0] SW_fall;

    typedef struct packed {
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    switch_debounce_sync #(
        .WIDTH   (W),
        .CNT_MAX (CM)
    ) dut (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .SW_raw   (SW_raw),
        .SW_clean (SW_clean),
        .SW_rise  (SW_rise),
        .SW_fall  (SW_fall)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_n(input int n, input logic [1:0] c, input logic [1:0] r,
                            input logic [1:0] f);
        exp_t e;
        e.clean = c;
        e.rise  = r;
        e.fall  = f;
        repeat (n) sb.push_back(e);
    endtask

    // Advance n clock edges; outputs are sampled on the following falling edge
    task automatic run(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s[%0d] scoreboard empty", tag, i);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s[%0d] clean/rise/fall", tag, i),
                      {2'b00, SW_clean, SW_rise, SW_fall}, {2'b00, e});
            end
        end
    endtask

    initial begin
        Resetn = 1'b1;
        SW_raw = 2'b11;
        #1;
        // 1: reset with switches high, then re-acceptance after release
        Resetn = 1'b0;
        #1;
        check("rst_async_outputs", {2'b00, SW_clean, SW_rise, SW_fall}, 8'h00);
        expect_n(3, 2'b00, 2'b00, 2'b00);
        run("rst_hold", 3);
        Resetn = 1'b1;
        expect_n(5, 2'b00, 2'b00, 2'b00);
        expect_n(1, 2'b11, 2'b11, 2'b00);
        expect_n(1, 2'b11, 2'b00, 2'b00);
        run("rst_release", 7);

        // both channels back low: simultaneous falls
        SW_raw = 2'b00;
        expect_n(5, 2'b11, 2'b00, 2'b00);
        expect_n(1, 2'b00, 2'b00, 2'b11);
        expect_n(1, 2'b00, 2'b00, 2'b00);
        run("both_fall", 7);

        // 2: clean step on channel 0
        SW_raw = 2'b01;
        expect_n(5, 2'b00, 2'b00, 2'b00);
        expect_n(1, 2'b01, 2'b01, 2'b00);
        expect_n(2, 2'b01, 2'b00, 2'b00);
        run("step", 8);

        SW_raw = 2'b00;
        expect_n(5, 2'b01, 2'b00, 2'b00);
        expect_n(1, 2'b00, 2'b00, 2'b01);
        expect_n(1, 2'b00, 2'b00, 2'b00);
        run("step_fall", 7);

        // 3: bounce 1,1,1,0 then 1 held; acceptance 5 edges after final rise
        SW_raw = 2'b01;
        expect_n(9, 2'b00, 2'b00, 2'b00);
        expect_n(1, 2'b01, 2'b01, 2'b00);
        expect_n(2, 2'b01, 2'b00, 2'b00);
        run("bounce_a", 3);
        SW_raw = 2'b00;
        run("bounce_b", 1);
        SW_raw = 2'b01;
        run("bounce_c", 8);

        // 4: single-cycle glitch on channel 1 rejected
        SW_raw = 2'b11;
        expect_n(8, 2'b01, 2'b00, 2'b00);
        run("glitch_a", 1);
        SW_raw = 2'b01;
        run("glitch_b", 7);
        check("glitch_state_lo", {6'd0, dut.g_chan[1].u_chan.r_state}, {6'd0, ST_LO});
        check("glitch_cnt_zero", {6'd0, dut.g_chan[1].u_chan.r_cnt}, 8'h00);

        // 5: 01 -> 10 in one cycle gives fall[0] and rise[1] together
        SW_raw = 2'b10;
        expect_n(5, 2'b01, 2'b00, 2'b00);
        expect_n(1, 2'b10, 2'b10, 2'b01);
        expect_n(2, 2'b10, 2'b00, 2'b00);
        run("simul", 8);

        // 6: reset while channel 0 is counting in WAIT_HI with cnt=2
        SW_raw = 2'b11;
        expect_n(4, 2'b10, 2'b00, 2'b00);
        run("midcnt", 4);
        check("midcnt_state", {6'd0, dut.g_chan[0].u_chan.r_state}, {6'd0, ST_WAIT_HI});
        check("midcnt_cnt", {6'd0, dut.g_chan[0].u_chan.r_cnt}, 8'h02);
        #1;
        Resetn = 1'b0;
        #1;
        check("midrst_outputs", {2'b00, SW_clean, SW_rise, SW_fall}, 8'h00);
        check("midrst_cnt", {6'd0, dut.g_chan[0].u_chan.r_cnt}, 8'h00);
        check("midrst_state", {6'd0, dut.g_chan[0].u_chan.r_state}, {6'd0, ST_LO});
        expect_n(2, 2'b00, 2'b00, 2'b00);
        run("midrst_hold", 2);
        Resetn = 1'b1;
        expect_n(5, 2'b00, 2'b00, 2'b00);
        expect_n(1, 2'b11, 2'b11, 2'b00);
        expect_n(2, 2'b11, 2'b00, 2'b00);
        run("midrst_release", 8);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain leftover=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
